// File: rtl/axi4_burst_mem_pkg.sv
// Shared types and helpers for the AXI4 burst memory slave.
package axi4_burst_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // A burst is usable only at full bus width, with a defined type, and WRAP needs 2/4/8/16 beats.
  function automatic logic burst_legal(input logic [2:0] size, input logic [2:0] full_size,
                                       input logic [1:0] burst, input logic [7:0] len);
    logic ok;
    ok = (size == full_size) && (burst != BURST_RSVD);
    if (burst == BURST_WRAP) begin
      ok = ok && ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    end
    return ok;
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts of full-width beats.
module axi4_burst_addr_gen
  import axi4_burst_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_LOG2  = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(1) << BEAT_LOG2;

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // WRAP keeps the container bits of the current address and lets only the low bits advance.
  always_comb begin
    incr_addr = addr + BEAT_BYTES;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << BEAT_LOG2) - ADDR_WIDTH'(1);
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 memory slave: one outstanding write burst and one outstanding read burst, byte strobes, SLVERR on bad beats.
module axi4_burst_mem_slave
  import axi4_burst_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [1:0]              rresp,
  output logic                    rlast
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int BEAT_LOG2 = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [2:0] FULL_SIZE = 3'(BEAT_LOG2);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << BEAT_LOG2) - ADDR_WIDTH'(1));

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic out_en;

  w_state_e w_state, w_state_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_next, w_word;
  logic [ADDR_WIDTH:0]   w_diff;
  logic                  w_legal, w_err, w_in_range, w_we;
  logic                  aw_hs, w_hs;

  r_state_e r_state, r_state_next;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_next, rd_addr, rd_word;
  logic [ADDR_WIDTH:0]   rd_diff;
  logic                  r_legal, rd_legal, rd_ok;
  logic                  ar_hs, r_more;

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BEAT_LOG2(BEAT_LOG2)) u_w_addr_gen (
    .addr(w_addr), .len(w_len), .burst(w_burst), .next_addr(w_addr_next)
  );

  axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BEAT_LOG2(BEAT_LOG2)) u_r_addr_gen (
    .addr(r_addr), .len(r_len), .burst(r_burst), .next_addr(r_addr_next)
  );

  // The extra top bit of the difference flags addresses below the memory base.
  assign w_diff     = {1'b0, w_addr} - {1'b0, BASE_ADDR};
  assign w_word     = w_diff[ADDR_WIDTH-1:0] >> BEAT_LOG2;
  assign w_in_range = !w_diff[ADDR_WIDTH] && (w_word < ADDR_WIDTH'(MEM_DEPTH));
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign w_we       = w_hs && w_legal && w_in_range;
  assign bid        = w_id;

  // Read side looks at the AR request while idle, otherwise at the beat after the current one.
  assign rd_addr  = (r_state == R_IDLE) ? (araddr & ALIGN_MASK) : r_addr_next;
  assign rd_legal = (r_state == R_IDLE) ? burst_legal(arsize, FULL_SIZE, arburst, arlen) : r_legal;
  assign rd_diff  = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
  assign rd_word  = rd_diff[ADDR_WIDTH-1:0] >> BEAT_LOG2;
  assign rd_ok    = rd_legal && !rd_diff[ADDR_WIDTH] && (rd_word < ADDR_WIDTH'(MEM_DEPTH));
  assign ar_hs    = arvalid && arready;
  assign r_more   = rvalid && rready && (r_cnt != r_len);

  // Holds both address-ready outputs low until the first clock after reset releases.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out_en <= 1'b0;
    else         out_en <= 1'b1;
  end

  // Write FSM next state and handshake outputs.
  always_comb begin
    w_state_next = w_state;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    bresp        = RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        awready = out_en;
        if (out_en && awvalid) w_state_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && (w_cnt == w_len)) w_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
        if (bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write state, burst context and the sticky error that becomes bresp.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_addr  <= '0;
      w_legal <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_next;
      if (aw_hs) begin
        w_id    <= awid;
        w_len   <= awlen;
        w_cnt   <= '0;
        w_burst <= awburst;
        w_addr  <= awaddr & ALIGN_MASK;
        w_legal <= burst_legal(awsize, FULL_SIZE, awburst, awlen);
        w_err   <= 1'b0;
      end else if (w_hs) begin
        w_cnt  <= w_cnt + 8'd1;
        w_addr <= w_addr_next;
        if (!w_we || (wlast != (w_cnt == w_len))) w_err <= 1'b1;
      end
    end
  end

  // Memory array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_word[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_state_next = r_state;
    arready      = 1'b0;
    rvalid       = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = out_en;
        if (out_en && arvalid) r_state_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && (r_cnt == r_len)) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read beats are registered a cycle ahead, which also gives read-before-write on collisions.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      rid     <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_addr  <= '0;
      r_legal <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
    end else begin
      r_state <= r_state_next;
      if (ar_hs || r_more) begin
        r_addr <= rd_addr;
        rdata  <= rd_ok ? mem[rd_word[IDX_W-1:0]] : '0;
        rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (ar_hs) begin
        rid     <= arid;
        r_len   <= arlen;
        r_cnt   <= '0;
        r_burst <= arburst;
        r_legal <= rd_legal;
        rlast   <= (arlen == 8'd0);
      end else if (r_more) begin
        r_cnt <= r_cnt + 8'd1;
        rlast <= ((r_cnt + 8'd1) == r_len);
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Randomised bench for axi4_burst_mem_slave against a word-array reference model.
module tb_axi4_burst_mem_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int DEPTH = 1024;
  localparam int LIMIT = 600;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [IW-1:0] awid = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wlast = 1'b0;
  logic          bvalid, bready = 1'b0;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic [IW-1:0] arid = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic          rvalid, rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic [1:0]    rresp;
  logic          rlast;

  always #5 clk = ~clk;

  axi4_burst_mem_slave dut (
    .clk(clk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_mem [DEPTH];
  rbeat_t      r_exp_q[$];
  bexp_t       b_exp_q[$];
  logic [31:0] wdata_q[$];
  logic [3:0]  wstrb_q[$];
  logic [31:0] rd_got[$];
  logic [1:0]  rresp_got[$];
  logic [1:0]  last_bresp;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=no_handshake required=handshake_within_%0d_cycles", name, LIMIT);
  endtask

  // Legality straight from the rules: full-width size, defined type, WRAP of 2/4/8/16 beats.
  function automatic bit legal_m(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    if (size != 3'd2) return 1'b0;
    if (burst == 2'b11) return 1'b0;
    if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
    return 1'b1;
  endfunction

  // Byte address of beat i, from start, burst type and container arithmetic.
  function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    logic [31:0] start, wb, base;
    start = addr & 32'hFFFF_FFFC;
    case (burst)
      2'b01: return start + 32'(4 * i);
      2'b10: begin
        wb   = (32'(len) + 32'd1) * 32'd4;
        base = start - (start % wb);
        return base + ((start - base + 32'(4 * i)) % wb);
      end
      default: return start;
    endcase
  endfunction

  function automatic bit in_range_m(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  function automatic bit wlast_for(input int i, input logic [7:0] len, input int early_last, input bit drop_last);
    bit wl;
    wl = (i == int'(len)) && !drop_last;
    if (i == early_last) wl = 1'b1;
    return wl;
  endfunction

  // Queue the expected R beats of a read (only the first nbeats, for aborted bursts).
  task automatic expect_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input int nbeats);
    rbeat_t e;
    logic [31:0] a;
    bit ok;
    for (int i = 0; i <= int'(len) && i < nbeats; i++) begin
      a = beat_addr(addr, len, burst, i);
      ok = legal_m(size, burst, len) && in_range_m(a);
      e.id   = id;
      e.data = ok ? model_mem[int'(a >> 2)] : 32'h0;
      e.resp = ok ? 2'b00 : 2'b10;
      e.last = (i == int'(len));
      r_exp_q.push_back(e);
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size;
    n = 0;
    forever begin
      @(negedge clk);
      if (arready) break;
      n++;
      if (n > LIMIT) begin timeoutFail("ar_handshake"); break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Full write burst: update the model, drive AW/W/B, record the response seen.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input int early_last, input bit drop_last, input bit gaps);
    bit err, wl, legal;
    logic [31:0] a, w;
    bexp_t be;
    int n;
    legal = legal_m(size, burst, len);
    err = !legal;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, len, burst, i);
      wl = wlast_for(i, len, early_last, drop_last);
      if (legal && in_range_m(a)) begin
        w = model_mem[int'(a >> 2)];
        for (int b = 0; b < 4; b++) if (wstrb_q[i][b]) w[b*8 +: 8] = wdata_q[i][b*8 +: 8];
        model_mem[int'(a >> 2)] = w;
      end else begin
        err = 1'b1;
      end
      if (wl != (i == int'(len))) err = 1'b1;
    end
    be.id = id;
    be.resp = err ? 2'b10 : 2'b00;
    b_exp_q.push_back(be);

    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size;
    n = 0;
    forever begin
      @(negedge clk);
      if (awready) break;
      n++;
      if (n > LIMIT) begin timeoutFail("aw_handshake"); break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    checkOutput("awready_drop", 64'(awready), 64'(0));

    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        wvalid = 1'b0;
        @(posedge clk); #1;
      end
      wvalid = 1'b1;
      wdata = wdata_q[i];
      wstrb = wstrb_q[i];
      wlast = wlast_for(i, len, early_last, drop_last);
      n = 0;
      forever begin
        @(negedge clk);
        if (wready) break;
        n++;
        if (n > LIMIT) begin timeoutFail("w_handshake"); break; end
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast = 1'b0;

    n = 0;
    forever begin
      bready = gaps ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
      if (bvalid && bready) begin last_bresp = bresp; break; end
      n++;
      if (n > LIMIT) begin timeoutFail("b_handshake"); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bready = 1'b0;
    checkOutput("awready_back", 64'(awready), 64'(1));
    wdata_q.delete();
    wstrb_q.delete();
  endtask

  // Full read burst with optional random back-pressure; collected beats go to rd_got/rresp_got.
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input bit rand_ready);
    int got, n;
    bit timed_out;
    rd_got.delete();
    rresp_got.delete();
    expect_read(id, addr, len, burst, size, 256);
    send_ar(id, addr, len, burst, size);
    got = 0;
    n = 0;
    timed_out = 1'b0;
    while (got <= int'(len)) begin
      rready = rand_ready ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
      if (rvalid && rready) begin
        rd_got.push_back(rdata);
        rresp_got.push_back(rresp);
        got++;
      end
      n++;
      if (n > LIMIT) begin timeoutFail("r_beats"); timed_out = 1'b1; break; end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (!timed_out) checkOutput("rvalid_after_last", 64'(rvalid), 64'(0));
  endtask

  // Compare process: every R and B handshake against the model queues, plus R hold-stability.
  rbeat_t prev_r;
  bit     prev_stall = 1'b0;
  initial begin
    rbeat_t cur, e;
    bexp_t  bcur, be;
    forever begin
      @(negedge clk);
      if (resetn) begin
        cur = '{id: rid, data: rdata, resp: rresp, last: rlast};
        if (prev_stall && rvalid) checkOutput("r_hold", 64'(cur), 64'(prev_r));
        if (rvalid && rready) begin
          if (r_exp_q.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL r_unexpected actual=%h required=no_beat", cur);
          end else begin
            e = r_exp_q.pop_front();
            checkOutput("r_beat", 64'(cur), 64'(e));
          end
        end
        prev_stall = rvalid && !rready;
        prev_r = cur;
        if (bvalid && bready) begin
          bcur = '{id: bid, resp: bresp};
          if (b_exp_q.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL b_unexpected actual=%h required=no_response", bcur);
          end else begin
            be = b_exp_q.pop_front();
            checkOutput("b_resp", 64'(bcur), 64'(be));
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Random mix of legal, illegal, out-of-range and misframed bursts.
  task automatic applyStimulus(input int count);
    int wl_opts[4] = '{1, 3, 7, 15};
    int r, early;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [31:0] addr;
    for (int t = 0; t < count; t++) begin
      r = int'($urandom % 10);
      burst = (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if (burst == 2'b10 && ($urandom % 8 != 0)) len = 8'(wl_opts[$urandom % 4]);
      else len = 8'($urandom % 16);
      size = ($urandom % 12 == 0) ? 3'($urandom % 8) : 3'd2;
      addr = ($urandom % 6 == 0) ? (32'h1000 - 32'($urandom % 64)) : 32'($urandom % (DEPTH * 4));
      if ($urandom % 2 == 0) begin
        for (int i = 0; i <= int'(len); i++) begin
          wdata_q.push_back($urandom);
          wstrb_q.push_back(4'($urandom));
        end
        early = ($urandom % 10 == 0) ? int'($urandom_range(0, int'(len))) : -1;
        write_burst(4'($urandom), addr, len, burst, size, early, ($urandom % 10 == 0), 1'b1);
      end else begin
        read_burst(4'($urandom), addr, len, burst, size, 1'b1);
      end
    end
  endtask

  initial begin
    #3_000_000;
    failures++;
    $display("[TB] FAIL watchdog actual=still_running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ctrl_outputs", 64'({awready, arready, wready, bvalid, rvalid, rlast}), 64'(0));
    checkOutput("reset_data_outputs", 64'({rdata, rresp, bresp, rid, bid}), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("awready_before_edge", 64'(awready), 64'(0));
    @(posedge clk); #1;
    checkOutput("ready_after_release", 64'({awready, arready}), 64'(2'b11));

    // Give every word a known value.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wdata_q.push_back($urandom);
        wstrb_q.push_back(4'hF);
      end
      write_burst(4'(blk), 32'(blk * 1024), 8'd255, 2'b01, 3'd2, -1, 1'b0, 1'b0);
    end

    // INCR write then read back.
    for (int i = 0; i < 4; i++) begin
      wdata_q.push_back(32'hA0 + 32'(i));
      wstrb_q.push_back(4'hF);
    end
    write_burst(4'h3, 32'h100, 8'd3, 2'b01, 3'd2, -1, 1'b0, 1'b1);
    checkOutput("incr_bresp", 64'(last_bresp), 64'(0));
    checkOutput("model_pin_a2", 64'(model_mem[32'h108 >> 2]), 64'(32'hA2));
    read_burst(4'h5, 32'h100, 8'd3, 2'b01, 3'd2, 1'b1);
    checkOutput("incr_read", 64'({rd_got[0][7:0], rd_got[1][7:0], rd_got[2][7:0], rd_got[3][7:0]}), 64'(32'hA0A1A2A3));

    // WRAP read from the middle of the 16-byte container.
    read_burst(4'h6, 32'h108, 8'd3, 2'b10, 3'd2, 1'b0);
    checkOutput("wrap_read", 64'({rd_got[0][7:0], rd_got[1][7:0], rd_got[2][7:0], rd_got[3][7:0]}), 64'(32'hA2A3A0A1));

    // Partial strobe merge.
    wdata_q.push_back(32'h1234_5678); wstrb_q.push_back(4'hF);
    write_burst(4'h1, 32'h200, 8'd0, 2'b01, 3'd2, -1, 1'b0, 1'b0);
    wdata_q.push_back(32'hFFFF_FFFF); wstrb_q.push_back(4'h3);
    write_burst(4'h2, 32'h200, 8'd0, 2'b01, 3'd2, -1, 1'b0, 1'b0);
    read_burst(4'h2, 32'h200, 8'd0, 2'b01, 3'd2, 1'b0);
    checkOutput("strobe_merge", 64'(rd_got[0]), 64'(32'h1234_FFFF));

    // Burst running off the end of memory.
    wdata_q.push_back(32'hCAFE_0001); wstrb_q.push_back(4'hF);
    wdata_q.push_back(32'hCAFE_0002); wstrb_q.push_back(4'hF);
    write_burst(4'h7, 32'hFFC, 8'd1, 2'b01, 3'd2, -1, 1'b0, 1'b0);
    checkOutput("oor_bresp", 64'(last_bresp), 64'(2'b10));
    read_burst(4'h7, 32'hFFC, 8'd1, 2'b01, 3'd2, 1'b0);
    checkOutput("oor_read", 64'({rd_got[0], rd_got[1], rresp_got[0], rresp_got[1]}), 64'({32'hCAFE_0001, 32'h0, 2'b00, 2'b10}));

    // Reserved burst type writes nothing.
    for (int i = 0; i < 3; i++) begin wdata_q.push_back(32'hDEAD_0000); wstrb_q.push_back(4'hF); end
    write_burst(4'h8, 32'h100, 8'd2, 2'b11, 3'd2, -1, 1'b0, 1'b0);
    checkOutput("illegal_bresp", 64'(last_bresp), 64'(2'b10));
    read_burst(4'h8, 32'h100, 8'd2, 2'b01, 3'd2, 1'b0);
    checkOutput("illegal_nochange", 64'({rd_got[0][7:0], rd_got[1][7:0], rd_got[2][7:0]}), 64'(24'hA0A1A2));

    // wlast on the first of two beats.
    wdata_q.push_back(32'h5555_0000); wstrb_q.push_back(4'hF);
    wdata_q.push_back(32'h5555_0001); wstrb_q.push_back(4'hF);
    write_burst(4'h9, 32'h300, 8'd1, 2'b01, 3'd2, 0, 1'b0, 1'b0);
    checkOutput("early_wlast_bresp", 64'(last_bresp), 64'(2'b10));

    applyStimulus(60);

    // Reset in the middle of an 8-beat read, after beat 1 has been taken.
    expect_read(4'hA, 32'h040, 8'd7, 2'b01, 3'd2, 2);
    send_ar(4'hA, 32'h040, 8'd7, 2'b01, 3'd2);
    rready = 1'b1;
    n = 0;
    while (n < 2) begin
      @(negedge clk);
      if (rvalid && rready) n++;
      else if (n == 0 && !rvalid) begin timeoutFail("abort_read_beats"); break; end
    end
    @(posedge clk); #1;
    checkOutput("abort_rvalid_before", 64'(rvalid), 64'(1));
    resetn = 1'b0;
    #1;
    rready = 1'b0;
    checkOutput("abort_outputs_zero", 64'({rvalid, arready, awready, rlast, rdata}), 64'(0));
    checkOutput("abort_queue_drained", 64'(r_exp_q.size()), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("arready_before_edge", 64'(arready), 64'(0));
    @(posedge clk); #1;
    checkOutput("arready_after_edge", 64'(arready), 64'(1));
    read_burst(4'hB, 32'h100, 8'd7, 2'b01, 3'd2, 1'b1);
    checkOutput("post_reset_contents", 64'({rd_got[0][7:0], rd_got[1][7:0]}), 64'(16'hA0A1));

    repeat (3) @(posedge clk);
    checkOutput("r_queue_empty", 64'(r_exp_q.size()), 64'(0));
    checkOutput("b_queue_empty", 64'(b_exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_burst_mem_slave.md
Name: axi4_burst_mem_slave

Overview:
- Synthesizable, parametrised AXI4 memory slave used as the DUT in the AXI4 project bench, in place of the VIP slave.
- Driven by the AXI4 master VIP and observed by the monitor VIP.
- Supports FIXED, INCR and WRAP bursts, byte strobes, and independent read and write channels with one outstanding burst each.
- Reports SLVERR on illegal or out-of-range accesses.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, read and write data width; must be 32, 64 or 128.
- ID_WIDTH, 4, AXI ID width.
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words.
- BASE_ADDR, 0, byte address of word 0.

Ports:
- clk  in  1  bench clock
- resetn  in  1  reset, active-low, asynchronous assert
- awvalid/awready  in/out  1  write-address handshake
- awaddr  in  ADDR_WIDTH  write start address
- awid  in  ID_WIDTH  write ID
- awlen  in  8  beats-1
- awsize  in  3  bytes per beat, log2
- awburst  in  2  burst type
- wvalid/wready  in/out  1  write-data handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte enables
- wlast  in  1  last write beat
- bvalid/bready  out/in  1  write-response handshake
- bid  out  ID_WIDTH  echoes awid
- bresp  out  2  OKAY or SLVERR
- arvalid/arready  in/out  1  read-address handshake
- araddr  in  ADDR_WIDTH  read start address
- arid  in  ID_WIDTH  read ID
- arlen  in  8  beats-1
- arsize  in  3  bytes per beat, log2
- arburst  in  2  burst type
- rvalid/rready  out/in  1  read-data handshake
- rdata  out  DATA_WIDTH  read data
- rid  out  ID_WIDTH  echoes arid
- rresp  out  2  per-beat response
- rlast  out  1  last read beat

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - Reset is asynchronous and active-low: resetn.
  - While resetn is low: all outputs are 0, both FSMs are IDLE, memory contents are not cleared.
  - awready and arready rise on the first clk edge after resetn deasserts.
- Burst legality:
  - A burst is illegal if the size is not equal to log2(DATA_WIDTH/8), or the burst type is 2'b11, or the burst is WRAP with len not in {1,3,7,15}.
  - An illegal burst still completes all len+1 beats.
  - Illegal write bursts write nothing and return bresp=SLVERR.
  - Illegal read bursts return rdata=0 and rresp=SLVERR on every beat.
- Address generation:
  - word = (addr-BASE_ADDR) >> log2(DATA_WIDTH/8).
  - Start addresses are aligned down to the beat size.
  - FIXED: address is constant for the whole burst.
  - INCR: address advances by one beat per beat.
  - WRAP: wraps at a boundary of (len+1)*beat bytes; container base = addr & ~((len+1)*beat-1).
  - INCR crossing 4KB is not checked.
  - If word >= MEM_DEPTH, or addr < BASE_ADDR, that beat is out of range.
- Write FSM (W_IDLE -> W_DATA -> W_RESP):
  - W_IDLE: awready=1. On AW handshake, latch id, len, burst and address; go to W_DATA; awready falls the next cycle.
  - W_DATA: wready=1. Each W handshake writes the enabled bytes at the current address, unless the burst is illegal or the beat is out of range.
    - A suppressed write sets the sticky error flag.
    - A beat counter counts to len.
  - On the beat where the counter equals len, go to W_RESP regardless of wlast.
    - If wlast is low on that beat, or high on any earlier beat, set the error flag.
  - W_RESP: bvalid=1, bid=latched id, bresp = error ? SLVERR : OKAY.
    - Outputs hold until bready.
    - The handshake returns the FSM to W_IDLE; awready=1 the following cycle.
- Read FSM (R_IDLE -> R_DATA):
  - R_IDLE: arready=1.
  - The AR handshake in cycle T gives rvalid=1 with beat 0 data in T+1.
  - Each R handshake presents the next beat in the following cycle, so back-to-back beats are possible with rready held high.
  - rlast=1 on beat len only.
  - rresp=SLVERR and rdata=0 on out-of-range beats.
  - The final handshake returns the FSM to R_IDLE.
  - While rvalid=1 and rready=0, all R outputs hold stable.
- Read/write collision: a same-cycle write and read to the same word gives the read the old data (read-before-write). Both channels run concurrently.
- Unsupported signals: no user, region, lock, cache, prot or qos ports. The bench leaves those interface signals unconnected.

Decomposition:
- axi4_burst_mem_pkg holds:
  - burst type enum (FIXED/INCR/WRAP)
  - resp constants (OKAY=2'b00, SLVERR=2'b10)
  - write and read state enums
  - function burst_legal()
- One sub-module: axi4_burst_addr_gen, a combinational next-address calculator for FIXED, INCR and WRAP. It is instantiated once for the write path and once for the read path.

Test Plan:
- INCR write awaddr=0x100, len=3, data 0xA0..0xA3, wstrb=0xF, then INCR read of the same range -> rdata A0,A1,A2,A3; rlast on beat 3; bresp=OKAY; rresp=OKAY.
- WRAP read araddr=0x108, len=3 (DATA_WIDTH=32) -> addresses 0x108, 0x10C, 0x100, 0x104, returning A2, A3, A0, A1.
- Single write wstrb=0x3, data 0xFFFF_FFFF onto a word holding 0x1234_5678 -> readback 0x1234_FFFF.
- Out-of-range INCR write at word MEM_DEPTH-1, len=1 -> beat 0 is written, beat 1 is suppressed, bresp=SLVERR. Read back with len=1 -> rresp OKAY then SLVERR.
- Illegal burst (awburst=2'b11, len=2) -> three W beats accepted, no memory change, bresp=SLVERR. Early wlast on beat 0 of a len=1 burst -> SLVERR.
- resetn pulsed low mid read burst (after beat 1 of len=7) -> rvalid=0 immediately. After release: arready=1 next edge, a fresh read returns the pre-reset memory contents.
